// File: rtl/stream_mux_rr.sv
// N:1 valid/ready stream mux with a single registered output stage; fixed-select or round-robin.
// Optional packet locking (in_last/out_last) is enabled with `define STREAM_MUX_LOCK_EN.
module stream_mux_rr #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 4,
  parameter int SEL_WIDTH  = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]            in_valid,
  output logic [NUM_CH-1:0]            in_ready,
`ifdef STREAM_MUX_LOCK_EN
  input  logic [NUM_CH-1:0]            in_last,
  output logic                         out_last,
`endif
  input  logic                         mode,
  input  logic [SEL_WIDTH-1:0]         sel,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [SEL_WIDTH-1:0]         out_ch
);

  logic [NUM_CH-1:0][DATA_WIDTH-1:0] data_arr;
  logic [SEL_WIDTH-1:0]              last_grant;
  logic [NUM_CH-1:0]                 grant;
  logic                              found;
  logic                              load_en;
  logic                              xfer;
  logic [SEL_WIDTH-1:0]              gnt_idx;
  logic [DATA_WIDTH-1:0]             gnt_data;

  assign data_arr = in_data;

`ifdef STREAM_MUX_LOCK_EN
  logic                 locked;
  logic [SEL_WIDTH-1:0] lock_ch;
  logic                 gnt_last;
`endif

  // Indices are matched by comparison so an out-of-range sel simply grants nothing.
  always_comb begin
    grant = '0;
    found = 1'b0;
`ifdef STREAM_MUX_LOCK_EN
    if (locked) begin
      for (int i = 0; i < NUM_CH; i++)
        if (int'(lock_ch) == i) grant[i] = in_valid[i];
    end else
`endif
    if (!mode) begin
      for (int i = 0; i < NUM_CH; i++)
        if (int'(sel) == i) grant[i] = in_valid[i];
    end else begin
      for (int k = 1; k <= NUM_CH; k++)
        for (int i = 0; i < NUM_CH; i++)
          if (!found && in_valid[i] && i == (int'(last_grant) + k) % NUM_CH) begin
            grant[i] = 1'b1;
            found    = 1'b1;
          end
    end
  end

  always_comb begin
    gnt_idx  = '0;
    gnt_data = '0;
`ifdef STREAM_MUX_LOCK_EN
    gnt_last = 1'b0;
`endif
    for (int i = 0; i < NUM_CH; i++)
      if (grant[i]) begin
        gnt_idx  = SEL_WIDTH'(i);
        gnt_data = data_arr[i];
`ifdef STREAM_MUX_LOCK_EN
        gnt_last = in_last[i];
`endif
      end
  end

  assign load_en  = !out_valid || out_ready;
  assign in_ready = (rst_n && load_en) ? grant : '0;
  assign xfer     = |(in_valid & in_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_ch     <= '0;
      last_grant <= SEL_WIDTH'(NUM_CH - 1);
`ifdef STREAM_MUX_LOCK_EN
      out_last   <= 1'b0;
      locked     <= 1'b0;
      lock_ch    <= '0;
`endif
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= gnt_data;
      out_ch    <= gnt_idx;
      if (mode) last_grant <= gnt_idx;
`ifdef STREAM_MUX_LOCK_EN
      out_last  <= gnt_last;
      locked    <= !gnt_last;
      lock_ch   <= gnt_idx;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: reset, fixed select, round-robin, backpressure, bad sel, reset in stall.
// Locking scenario runs when STREAM_MUX_LOCK_EN is defined.
module tb_stream_mux_rr;
  localparam int DW = 32;
  localparam int NC = 4;
  localparam int SW = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NC*DW-1:0]  in_data;
  logic [NC-1:0]     in_valid;
  logic [NC-1:0]     in_ready;
  logic              mode;
  logic [SW-1:0]     sel;
  logic [DW-1:0]     out_data;
  logic              out_valid;
  logic              out_ready;
  logic [SW-1:0]     out_ch;
`ifdef STREAM_MUX_LOCK_EN
  logic [NC-1:0]     in_last;
  logic              out_last;
`endif

  int vecs = 0;
  int errs = 0;

  stream_mux_rr #(.DATA_WIDTH(DW), .NUM_CH(NC), .SEL_WIDTH(SW)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
`ifdef STREAM_MUX_LOCK_EN
    .in_last(in_last), .out_last(out_last),
`endif
    .mode(mode), .sel(sel), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_ch(out_ch)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [DW-1:0] base);
    for (int i = 0; i < NC; i++) in_data[i*DW +: DW] = base | DW'(i);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = '0; out_ready = 1'b0; mode = 1'b1; sel = '0;
`ifdef STREAM_MUX_LOCK_EN
    in_last = '0;
`endif
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 4'hF; out_ready = 1'b1; mode = 1'b1; sel = '0;
`ifdef STREAM_MUX_LOCK_EN
    in_last = '0;
`endif
    set_data(32'hD000_0000);
    for (int c = 0; c < 2; c++) begin
      tick();
      vecs++; if (in_ready !== 4'b0000) begin errs++; $display("FAIL reset_in_ready got=%b exp=0000", in_ready); end
      vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      vecs++; if (out_data !== 32'h0) begin errs++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
      vecs++; if (out_ch !== 3'd0) begin errs++; $display("FAIL reset_out_ch got=%0d exp=0", out_ch); end
    end
    rst_n = 1'b1; #1;
    vecs++; if (in_ready !== 4'b0001) begin errs++; $display("FAIL reset_first_grant got=%b exp=0001", in_ready); end
    tick();
    vecs++; if (out_valid !== 1'b1 || out_ch !== 3'd0 || out_data !== 32'hD000_0000)
      begin errs++; $display("FAIL reset_first_beat got v=%b ch=%0d d=%h exp v=1 ch=0 d=d0000000", out_valid, out_ch, out_data); end
  endtask

  task automatic test_fixed();
    do_reset();
    mode = 1'b0; sel = 3'd2; in_valid = 4'hF; out_ready = 1'b1;
    set_data(32'hA5A5_0000); #1;
    vecs++; if (in_ready !== 4'b0100) begin errs++; $display("FAIL fixed_in_ready got=%b exp=0100", in_ready); end
    tick();
    vecs++; if (out_data !== 32'hA5A5_0002) begin errs++; $display("FAIL fixed_out_data got=%h exp=a5a50002", out_data); end
    vecs++; if (out_ch !== 3'd2 || out_valid !== 1'b1) begin errs++; $display("FAIL fixed_out_ch got ch=%0d v=%b exp ch=2 v=1", out_ch, out_valid); end
    #1;
    vecs++; if (in_ready !== 4'b0100) begin errs++; $display("FAIL fixed_in_ready_2 got=%b exp=0100", in_ready); end
  endtask

  task automatic test_round_robin();
    do_reset();
    mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
    set_data(32'hD000_0000);
    for (int k = 0; k < 6; k++) begin
      tick();
      vecs++;
      if (out_valid !== 1'b1 || out_ch !== SW'(k % 4) || out_data !== (32'hD000_0000 | 32'(k % 4))) begin
        errs++; $display("FAIL rr_seq[%0d] got v=%b ch=%0d d=%h exp v=1 ch=%0d", k, out_valid, out_ch, out_data, k % 4);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    mode = 1'b1; in_valid = 4'b0010; out_ready = 1'b1;
    in_data = '0; in_data[1*DW +: DW] = 32'h1234_5678; in_data[3*DW +: DW] = 32'h3333_0003; #1;
    vecs++; if (in_ready !== 4'b0010) begin errs++; $display("FAIL bp_load_ready got=%b exp=0010", in_ready); end
    tick();
    vecs++; if (out_data !== 32'h1234_5678 || out_ch !== 3'd1) begin errs++; $display("FAIL bp_loaded got d=%h ch=%0d exp d=12345678 ch=1", out_data, out_ch); end
    out_ready = 1'b0; in_valid = 4'b1000;
    for (int c = 0; c < 3; c++) begin
      #1;
      vecs++; if (in_ready !== 4'b0000) begin errs++; $display("FAIL bp_stall_ready[%0d] got=%b exp=0000", c, in_ready); end
      tick();
      vecs++; if (out_valid !== 1'b1 || out_data !== 32'h1234_5678 || out_ch !== 3'd1)
        begin errs++; $display("FAIL bp_hold[%0d] got v=%b d=%h ch=%0d exp v=1 d=12345678 ch=1", c, out_valid, out_data, out_ch); end
    end
    out_ready = 1'b1; #1;
    vecs++; if (in_ready !== 4'b1000) begin errs++; $display("FAIL bp_release_ready got=%b exp=1000", in_ready); end
    tick();
    vecs++; if (out_valid !== 1'b1 || out_data !== 32'h3333_0003 || out_ch !== 3'd3)
      begin errs++; $display("FAIL bp_no_gap got v=%b d=%h ch=%0d exp v=1 d=33330003 ch=3", out_valid, out_data, out_ch); end
    in_valid = '0;
    tick();
    vecs++; if (out_valid !== 1'b0 || out_data !== 32'h3333_0003) begin errs++; $display("FAIL bp_drain got v=%b d=%h exp v=0 d=33330003", out_valid, out_data); end
  endtask

  task automatic test_bad_sel();
    do_reset();
    mode = 1'b1; in_valid = 4'b0001; out_ready = 1'b0;
    in_data = '0; in_data[0 +: DW] = 32'hC0C0_0000;
    tick();
    vecs++; if (out_valid !== 1'b1 || out_ch !== 3'd0) begin errs++; $display("FAIL badsel_load got v=%b ch=%0d exp v=1 ch=0", out_valid, out_ch); end
    mode = 1'b0; sel = 3'd5; in_valid = 4'hF; out_ready = 1'b1; #1;
    vecs++; if (in_ready !== 4'b0000) begin errs++; $display("FAIL badsel_ready got=%b exp=0000", in_ready); end
    tick();
    vecs++; if (out_valid !== 1'b0 || out_data !== 32'hC0C0_0000 || out_ch !== 3'd0)
      begin errs++; $display("FAIL badsel_drain got v=%b d=%h ch=%0d exp v=0 d=c0c00000 ch=0", out_valid, out_data, out_ch); end
    tick();
    vecs++; if (out_valid !== 1'b0 || in_ready !== 4'b0000) begin errs++; $display("FAIL badsel_idle got v=%b rdy=%b exp v=0 rdy=0000", out_valid, in_ready); end
  endtask

  task automatic test_reset_in_stall();
    do_reset();
    mode = 1'b1; in_valid = 4'b0100; out_ready = 1'b0;
    set_data(32'hBEEF_0000);
    tick();
    vecs++; if (out_ch !== 3'd2 || out_valid !== 1'b1) begin errs++; $display("FAIL rststall_load got ch=%0d v=%b exp ch=2 v=1", out_ch, out_valid); end
    rst_n = 1'b0; in_valid = 4'hF;
    tick();
    vecs++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_ch !== 3'd0)
      begin errs++; $display("FAIL rststall_clear got v=%b d=%h ch=%0d exp v=0 d=0 ch=0", out_valid, out_data, out_ch); end
    rst_n = 1'b1; out_ready = 1'b1; #1;
    vecs++; if (in_ready !== 4'b0001) begin errs++; $display("FAIL rststall_ptr got=%b exp=0001", in_ready); end
    in_valid = '0;
    tick();
  endtask

`ifdef STREAM_MUX_LOCK_EN
  task automatic test_lock();
    do_reset();
    mode = 1'b1; in_valid = 4'b0110; out_ready = 1'b1; in_last = '0;
    set_data(32'hF00D_0000);
    for (int k = 0; k < 3; k++) begin
      in_last[1] = (k == 2);
      tick();
      vecs++; if (out_ch !== 3'd1 || out_last !== (k == 2))
        begin errs++; $display("FAIL lock_beat[%0d] got ch=%0d last=%b exp ch=1 last=%b", k, out_ch, out_last, (k == 2)); end
    end
    in_last = '0;
    tick();
    vecs++; if (out_ch !== 3'd2 || out_last !== 1'b0) begin errs++; $display("FAIL lock_after got ch=%0d last=%b exp ch=2 last=0", out_ch, out_last); end
    in_valid = 4'b0001; #1;
    vecs++; if (in_ready !== 4'b0000) begin errs++; $display("FAIL lock_idle_block got=%b exp=0000", in_ready); end
  endtask
`endif

  initial begin
    in_data = '0;
    test_reset();
    test_fixed();
    test_round_robin();
    test_backpressure();
    test_bad_sel();
    test_reset_in_stall();
`ifdef STREAM_MUX_LOCK_EN
    test_lock();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised N:1 streaming multiplexer; successor to the combinational 2:1 multiplexer2.
- Each input is a valid/ready channel; one registered output stage.
- Two modes: fixed select (multiplexer2 behaviour, but registered) and round-robin arbitration.
- Used where several producers feed one consumer, e.g. writeback/bus-master merging in the RV32i core.

Parameters:
- DATA_WIDTH, 32, width of each data channel.
- NUM_CH, 4, number of input channels; legal range 2..16.
- SEL_WIDTH, 2, width of sel/out_ch; must be at least $clog2(NUM_CH).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_data  input  NUM_CH*DATA_WIDTH  flat input bus; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_valid  input  NUM_CH  per-channel valid.
- in_ready  output  NUM_CH  per-channel ready (combinational).
- mode  input  1  0 = fixed select by sel; 1 = round-robin.
- sel  input  SEL_WIDTH  channel select used in mode 0.
- out_data  output  DATA_WIDTH  registered output data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  downstream ready.
- out_ch  output  SEL_WIDTH  index of the channel whose beat is in out_data.

Behaviour:
- Reset (rst_n=0 at posedge):
  - out_valid=0, out_data=0, out_ch=0.
  - Round-robin pointer last_grant=NUM_CH-1, so ch0 has first priority.
  - in_ready=0 while rst_n=0.
- Output register:
  - load_en = !out_valid || out_ready (empty, or draining this cycle).
- Grant (combinational, one-hot, at most one bit):
  - Mode 0: grant[sel] = in_valid[sel].
  - Mode 0, sel >= NUM_CH: no grant; output register drains normally.
  - Mode 1: first i with in_valid[i], searching upward from last_grant+1 modulo NUM_CH.
- in_ready[i] = grant[i] && load_en.
  - A ready never depends on in_valid of another channel in mode 0.
- Transfer on channel i when in_valid[i] && in_ready[i]:
  - Next edge: out_data <= in_data[i], out_ch <= i, out_valid <= 1.
  - In mode 1 only: last_grant <= i.
- No transfer and out_ready && out_valid: out_valid <= 0; out_data and out_ch hold.
- Latency: exactly 1 cycle, input handshake to out_valid.
- Throughput: 1 beat/cycle when out_ready is held high.
- Stall (out_valid && !out_ready): out_data and out_ch hold stable; all in_ready=0.
- Simultaneous drain and load in the same cycle: the new beat replaces the old one, with no bubble.
- Mode or sel change mid-stream: takes effect in the next grant calculation. The beat already in the register is unaffected.
- Reset asserted mid-stall: the held beat is discarded; last_grant reinitialised.
- Wrap-around: from last_grant=NUM_CH-1 the search starts at ch0.
- No combinational path from in_* to out_*.

Optional Feature:
- Macro: STREAM_MUX_LOCK_EN.
- With the macro defined:
  - Adds ports in_last (input, NUM_CH) and out_last (output, 1, registered, reset 0).
  - Once a beat with in_last=0 is accepted from channel i, the grant locks to i, in both modes, until a beat with in_last=1 from i is accepted.
  - While locked, other channels see in_ready=0 even if the locked channel is idle.
  - A lock in progress is cleared by reset only.
- Without the macro: no in_last/out_last ports; every beat is arbitrated independently.

Test Plan:
- Reset, then idle: hold rst_n=0 for 2 cycles with all in_valid=1 -> in_ready=0, out_valid=0, out_data=0. On the first cycle after release, ch0 is granted (mode 1).
- Mode 0, sel=2:
  - Send in_data ch2=0xA5A5_0002 with out_ready=1 -> next cycle out_data=0xA5A5_0002, out_ch=2.
  - ch0/1/3 valid throughout -> their in_ready stays 0.
- Mode 1, all four valid continuously, out_ready=1 -> out_ch sequence 0,1,2,3,0,1 on consecutive cycles, no bubbles.
- Backpressure: beat from ch1 = 0x1234_5678 in the register, out_ready=0 for 3 cycles -> out_data and out_ch hold, all in_ready=0. Then out_ready=1 with ch3 valid -> ch3 loaded on the same edge, no gap cycle.
- Mode 0 with sel=5, NUM_CH=4: all in_ready=0, out_valid falls after the pending beat drains.
- With STREAM_MUX_LOCK_EN, mode 1: ch1 sends 3 beats with in_last=0,0,1 while ch2 is valid -> out_ch=1,1,1, then 2. out_last=1 only on the third beat.
